// File: rtl/i2c_slave_addr_ack_pkg.sv
// Shared I2C slave definitions: FSM state encoding, address constants and
// the address-compare helper used by the address/ACK stage.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX        = 3'd1,
        ST_ACK_SETUP = 3'd2,
        ST_ACK_HIGH  = 3'd3,
        ST_ACK_HOLD  = 3'd4,
        ST_NACK      = 3'd5
    } state_t;

    localparam logic [7:0] GENERAL_CALL_ADDR = 8'h00;
    localparam logic       RW_READ           = 1'b1;
    localparam logic       RW_WRITE          = 1'b0;

    function automatic logic addr_hit(input logic [7:0] addr_byte,
                                      input logic [6:0] own_addr,
                                      input logic       gc_en);
        return (addr_byte[7:1] == own_addr) ||
               (gc_en && (addr_byte == GENERAL_CALL_ADDR));
    endfunction

endpackage

// File: rtl/i2c_slave_addr_ack_chk.sv
// Property checker for the address/ACK stage: SDA may only be pulled low
// while the slave is actually acknowledging.
module i2c_slave_addr_ack_chk
    import i2c_pkg::*;
(
    input logic   i_clock,
    input logic   i_reset,
    input state_t i_state,
    input logic   i_sda_drive_low
);

    a_sda_only_in_ack: assert property (@(posedge i_clock) disable iff (i_reset)
        !(i_sda_drive_low && (i_state inside {ST_IDLE, ST_RX, ST_NACK})));

endmodule

// File: rtl/i2c_slave_addr_ack.sv
// Address phase of an I2C slave: starts the byte reader, compares the first
// byte after START with the own address and drives the 9th-clock ACK on a hit.
module i2c_slave_addr_ack
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR      = 7'h50,
    parameter logic       GENERAL_CALL_EN = 1'b0,
    parameter int         TIMEOUT_CYCLES  = 4096
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_bus_abort,
    input  logic       i_scl,
    input  logic [7:0] i_byte_data,
    input  logic       i_byte_finish,
    input  logic       i_byte_error,
    output logic       o_byte_enable,
    output logic       o_sda_drive_low,
    output logic       o_match,
    output logic       o_rw,
    output logic       o_busy,
    output logic       o_error,
    output logic       o_finish
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic             r_scl_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_nack_rise, w_nack_rise_nxt;
    logic             r_sda, w_sda_nxt;
    logic             r_match, w_match_nxt;
    logic             r_rw, w_rw_nxt;
    logic             r_error, w_error_nxt;
    logic             r_finish, w_finish_nxt;
    logic             w_rise, w_fall, w_counting, w_timeout;

    assign w_rise     = ~r_scl_last & i_scl;
    assign w_fall     = r_scl_last & ~i_scl;
    assign w_counting = r_state inside {ST_ACK_SETUP, ST_ACK_HIGH, ST_ACK_HOLD, ST_NACK};
    assign w_timeout  = w_counting && (r_cnt == CNT_LAST);

    // Next-state and next-output decode; abort outranks timeout, which outranks normal progress.
    always_comb begin
        w_state_nxt     = r_state;
        w_nack_rise_nxt = r_nack_rise;
        w_sda_nxt       = r_sda;
        w_match_nxt     = r_match;
        w_rw_nxt        = r_rw;
        w_error_nxt     = r_error;
        w_finish_nxt    = 1'b0;
        if (i_bus_abort && (r_state != ST_IDLE)) begin
            w_state_nxt  = ST_IDLE;
            w_sda_nxt    = 1'b0;
            w_match_nxt  = 1'b0;
            w_finish_nxt = 1'b1;
        end else if (w_timeout) begin
            w_state_nxt  = ST_IDLE;
            w_sda_nxt    = 1'b0;
            w_match_nxt  = 1'b0;
            w_error_nxt  = 1'b1;
            w_finish_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        w_state_nxt = ST_RX;
                        w_match_nxt = 1'b0;
                        w_error_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RX: begin
                    if (i_byte_error) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_error_nxt = r_error;
                    end
                    if (i_byte_finish) begin
                        w_rw_nxt        = i_byte_data[0];
                        w_nack_rise_nxt = 1'b0;
                        w_state_nxt     = addr_hit(i_byte_data, SLAVE_ADDR, GENERAL_CALL_EN)
                                          ? ST_ACK_SETUP : ST_NACK;
                    end else begin
                        w_state_nxt = ST_RX;
                    end
                end
                // SCL level, not edge: the byte may finish after SCL has already fallen.
                ST_ACK_SETUP: begin
                    if (!i_scl) begin
                        w_sda_nxt   = 1'b1;
                        w_state_nxt = ST_ACK_HIGH;
                    end else begin
                        w_state_nxt = ST_ACK_SETUP;
                    end
                end
                ST_ACK_HIGH: begin
                    if (w_rise) begin
                        w_state_nxt = ST_ACK_HOLD;
                    end else begin
                        w_state_nxt = ST_ACK_HIGH;
                    end
                end
                ST_ACK_HOLD: begin
                    if (w_fall) begin
                        w_state_nxt  = ST_IDLE;
                        w_sda_nxt    = 1'b0;
                        w_match_nxt  = 1'b1;
                        w_finish_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACK_HOLD;
                    end
                end
                ST_NACK: begin
                    if (w_rise) begin
                        w_nack_rise_nxt = 1'b1;
                    end else if (w_fall && r_nack_rise) begin
                        w_state_nxt  = ST_IDLE;
                        w_match_nxt  = 1'b0;
                        w_finish_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_NACK;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sda_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State, output and timeout-counter registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_scl_last  <= 1'b1;
            r_cnt       <= '0;
            r_nack_rise <= 1'b0;
            r_sda       <= 1'b0;
            r_match     <= 1'b0;
            r_rw        <= 1'b0;
            r_error     <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_scl_last  <= i_scl;
            r_cnt       <= ((w_state_nxt != r_state) || !w_counting) ? '0 : r_cnt + CNT_W'(1);
            r_nack_rise <= w_nack_rise_nxt;
            r_sda       <= w_sda_nxt;
            r_match     <= w_match_nxt;
            r_rw        <= w_rw_nxt;
            r_error     <= w_error_nxt;
            r_finish    <= w_finish_nxt;
        end
    end

    assign o_byte_enable   = i_enable && (r_state == ST_IDLE);
    assign o_sda_drive_low = r_sda;
    assign o_match         = r_match;
    assign o_rw            = r_rw;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_error         = r_error;
    assign o_finish        = r_finish;

    i2c_slave_addr_ack_chk u_chk (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_state         (r_state),
        .i_sda_drive_low (r_sda)
    );

endmodule
